// File: rtl/axi_mtimer_pkg.sv
// Shared AXI channel types, register offsets and FSM states for the machine timer.
package axi_mtimer_pkg;

   localparam int unsigned AXI_ID_W = 4;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [15:0] MTIMER_MSIP_OFF    = 16'h0000;
   localparam logic [15:0] MTIMER_CMP_LO_OFF  = 16'h4000;
   localparam logic [15:0] MTIMER_CMP_HI_OFF  = 16'h4004;
   localparam logic [15:0] MTIMER_TIME_LO_OFF = 16'hBFF8;
   localparam logic [15:0] MTIMER_TIME_HI_OFF = 16'hBFFC;

   typedef struct packed {
      logic [31:0]         awaddr;
      logic [AXI_ID_W-1:0] awid;
      logic [7:0]          awlen;
      logic                awvalid;
      logic [31:0]         wdata;
      logic [3:0]          wstrb;
      logic                wlast;
      logic                wvalid;
      logic                bready;
      logic [31:0]         araddr;
      logic [AXI_ID_W-1:0] arid;
      logic [7:0]          arlen;
      logic                arvalid;
      logic                rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                awready;
      logic                wready;
      logic                bvalid;
      logic [AXI_ID_W-1:0] bid;
      logic [1:0]          bresp;
      logic                arready;
      logic                rvalid;
      logic [AXI_ID_W-1:0] rid;
      logic [31:0]         rdata;
      logic [1:0]          rresp;
      logic                rlast;
   } s_axi_miso_t;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} mtimer_wr_st_t;
   typedef enum logic {R_IDLE, R_DATA} mtimer_rd_st_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

   function automatic logic mtimer_mapped(input logic [15:0] off);
      return (off == MTIMER_MSIP_OFF)    || (off == MTIMER_CMP_LO_OFF) ||
             (off == MTIMER_CMP_HI_OFF)  || (off == MTIMER_TIME_LO_OFF) ||
             (off == MTIMER_TIME_HI_OFF);
   endfunction

endpackage

// File: rtl/axi_mtimer_regif.sv
// Generic AXI slave front end: independent write/read handshake FSMs that turn
// accepted beats into single-cycle register write and read strobes.
module axi_mtimer_regif
   import axi_mtimer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  s_axi_mosi_t axi_mosi_i,
   output s_axi_miso_t axi_miso_o,
   output logic        wr_en_o,
   output logic [15:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   output logic [3:0]  wr_strb_o,
   input  logic        wr_err_i,
   output logic        rd_en_o,
   output logic [15:0] rd_addr_o,
   input  logic [31:0] rd_data_i,
   input  logic        rd_err_i
);

   mtimer_wr_st_t       wr_st_q;
   logic                awready_q, bvalid_q;
   logic [AXI_ID_W-1:0] bid_q;
   logic [1:0]          bresp_q;
   logic [15:0]         waddr_q;
   logic [7:0]          wlen_q;

   mtimer_rd_st_t       rd_st_q;
   logic                arready_q, rvalid_q, rlast_q;
   logic [AXI_ID_W-1:0] rid_q;
   logic [31:0]         rdata_q;
   logic [1:0]          rresp_q;
   logic [7:0]          rcnt_q;

   logic aw_hs, w_ready, w_hs, ar_hs;
   logic [7:0] w_len_eff;

   assign aw_hs = axi_mosi_i.awvalid & awready_q;
   // A W beat is only taken once its address is known, either this cycle or latched.
   assign w_ready = (wr_st_q == W_DATA) | aw_hs;
   assign w_hs = axi_mosi_i.wvalid & w_ready;
   assign w_len_eff = aw_hs ? axi_mosi_i.awlen : wlen_q;
   assign ar_hs = axi_mosi_i.arvalid & arready_q;

   assign wr_en_o   = w_hs & (w_len_eff == 8'd0);
   assign wr_addr_o = aw_hs ? axi_mosi_i.awaddr[15:0] : waddr_q;
   assign wr_data_o = axi_mosi_i.wdata;
   assign wr_strb_o = axi_mosi_i.wstrb;
   assign rd_en_o   = ar_hs;
   assign rd_addr_o = axi_mosi_i.araddr[15:0];

   logic unused_addr_hi;
   assign unused_addr_hi = ^{axi_mosi_i.awaddr[31:16], axi_mosi_i.araddr[31:16]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_st_q   <= W_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= AXI_RESP_OKAY;
         waddr_q   <= '0;
         wlen_q    <= '0;
      end else begin
         unique case (wr_st_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (aw_hs) begin
                  awready_q <= 1'b0;
                  waddr_q   <= axi_mosi_i.awaddr[15:0];
                  wlen_q    <= axi_mosi_i.awlen;
                  bid_q     <= axi_mosi_i.awid;
                  bresp_q   <= AXI_RESP_OKAY;
                  wr_st_q   <= W_DATA;
                  if (w_hs) begin
                     if (w_len_eff != 8'd0 || wr_err_i) bresp_q <= AXI_RESP_SLVERR;
                     if (axi_mosi_i.wlast) begin
                        bvalid_q <= 1'b1;
                        wr_st_q  <= W_RESP;
                     end
                  end
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  if (w_len_eff != 8'd0 || wr_err_i) bresp_q <= AXI_RESP_SLVERR;
                  if (axi_mosi_i.wlast) begin
                     bvalid_q <= 1'b1;
                     wr_st_q  <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (axi_mosi_i.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wr_st_q   <= W_IDLE;
               end
            end
            default: wr_st_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_st_q   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
         rcnt_q    <= '0;
      end else begin
         unique case (rd_st_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rid_q     <= axi_mosi_i.arid;
                  rcnt_q    <= axi_mosi_i.arlen;
                  rlast_q   <= (axi_mosi_i.arlen == 8'd0);
                  rd_st_q   <= R_DATA;
                  // Data is captured here, so every beat returns this snapshot.
                  if (axi_mosi_i.arlen != 8'd0 || rd_err_i) begin
                     rdata_q <= '0;
                     rresp_q <= AXI_RESP_SLVERR;
                  end else begin
                     rdata_q <= rd_data_i;
                     rresp_q <= AXI_RESP_OKAY;
                  end
               end
            end
            R_DATA: begin
               if (axi_mosi_i.rready) begin
                  if (rcnt_q == 8'd0) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     rd_st_q   <= R_IDLE;
                  end else begin
                     rcnt_q  <= rcnt_q - 8'd1;
                     rlast_q <= (rcnt_q == 8'd1);
                  end
               end
            end
            default: rd_st_q <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      axi_miso_o         = '0;
      axi_miso_o.awready = awready_q;
      axi_miso_o.wready  = w_ready;
      axi_miso_o.bvalid  = bvalid_q;
      axi_miso_o.bid     = bid_q;
      axi_miso_o.bresp   = bresp_q;
      axi_miso_o.arready = arready_q;
      axi_miso_o.rvalid  = rvalid_q;
      axi_miso_o.rid     = rid_q;
      axi_miso_o.rdata   = rdata_q;
      axi_miso_o.rresp   = rresp_q;
      axi_miso_o.rlast   = rlast_q;
   end

endmodule

// File: rtl/axi_mtimer.sv
// CLINT-style machine timer / software interrupt slave. Define MTIMER_REG_IRQ_EN
// to drive timer_irq_o and sw_irq_o from flops (one extra cycle of latency).
module axi_mtimer
   import axi_mtimer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
   parameter int unsigned PRESCALER = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  s_axi_mosi_t axi_mosi,
   output s_axi_miso_t axi_miso,
   output logic        timer_irq_o,
   output logic        sw_irq_o
);

   localparam logic [15:0] PreMax = 16'(PRESCALER - 1);

   logic        wr_en, wr_err, rd_en, rd_err;
   logic [15:0] wr_addr, rd_addr, wr_off, rd_off;
   logic [31:0] wr_data, rd_data;
   logic [3:0]  wr_strb;

   logic [15:0] pre_q, pre_d;
   logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d, tick, timer_hit;

   axi_mtimer_regif u_regif (
      .clk        (clk),
      .rst        (rst),
      .axi_mosi_i (axi_mosi),
      .axi_miso_o (axi_miso),
      .wr_en_o    (wr_en),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data),
      .wr_strb_o  (wr_strb),
      .wr_err_i   (wr_err),
      .rd_en_o    (rd_en),
      .rd_addr_o  (rd_addr),
      .rd_data_i  (rd_data),
      .rd_err_i   (rd_err)
   );

   // Reads have no side effects, so the read strobe is not needed here.
   logic unused_rd_en;
   assign unused_rd_en = rd_en;

   assign wr_off = wr_addr - BASE_ADDR[15:0];
   assign rd_off = rd_addr - BASE_ADDR[15:0];
   assign wr_err = !mtimer_mapped(wr_off);
   assign tick   = (pre_q == PreMax);

   always_comb begin
      pre_d      = tick ? 16'd0 : pre_q + 16'd1;
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (tick) mtime_d = mtime_q + 64'd1;
      if (wr_en) begin
         case (wr_off)
            MTIMER_MSIP_OFF:    if (wr_strb[0]) msip_d = wr_data[0];
            MTIMER_CMP_LO_OFF:  mtimecmp_d[31:0]  = apply_strb(mtimecmp_q[31:0], wr_data, wr_strb);
            MTIMER_CMP_HI_OFF:  mtimecmp_d[63:32] = apply_strb(mtimecmp_q[63:32], wr_data, wr_strb);
            // A software write to mtime overrides a coincident tick.
            MTIMER_TIME_LO_OFF: mtime_d = {mtime_q[63:32],
                                           apply_strb(mtime_q[31:0], wr_data, wr_strb)};
            MTIMER_TIME_HI_OFF: mtime_d = {apply_strb(mtime_q[63:32], wr_data, wr_strb),
                                           mtime_q[31:0]};
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (rd_off)
         MTIMER_MSIP_OFF:    rd_data = {31'd0, msip_q};
         MTIMER_CMP_LO_OFF:  rd_data = mtimecmp_q[31:0];
         MTIMER_CMP_HI_OFF:  rd_data = mtimecmp_q[63:32];
         MTIMER_TIME_LO_OFF: rd_data = mtime_q[31:0];
         MTIMER_TIME_HI_OFF: rd_data = mtime_q[63:32];
         default:            rd_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q      <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
      end
   end

   assign timer_hit = (mtime_q >= mtimecmp_q);

`ifdef MTIMER_REG_IRQ_EN
   logic timer_irq_q, sw_irq_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_irq_q <= 1'b0;
         sw_irq_q    <= 1'b0;
      end else begin
         timer_irq_q <= timer_hit;
         sw_irq_q    <= msip_q;
      end
   end

   assign timer_irq_o = timer_irq_q;
   assign sw_irq_o    = sw_irq_q;
`else
   assign timer_irq_o = timer_hit;
   assign sw_irq_o    = msip_q;
`endif

endmodule

// File: tb/tb_axi_mtimer.sv
// Randomized self-checking bench for axi_mtimer against a time-based reference model.
module tb_axi_mtimer;
   import axi_mtimer_pkg::*;

   localparam int unsigned Prescaler = 1;
   localparam logic [31:0] Base = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;
   logic        timer_irq, sw_irq;

   int errors = 0;
   int checks = 0;

   // Model: mtime = m_base + (ticks since reset) - m_base_ticks; edges counts clock edges out of reset.
   longint unsigned edges;
   logic [63:0]     m_base;
   longint unsigned m_base_ticks;
   logic [63:0]     m_cmp;
   logic            m_msip;
   logic [15:0]     offs [6];

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   axi_mtimer #(
      .BASE_ADDR (Base),
      .PRESCALER (Prescaler)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .axi_mosi    (mosi),
      .axi_miso    (miso),
      .timer_irq_o (timer_irq),
      .sw_irq_o    (sw_irq)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_time(input longint unsigned e);
      return m_base + 64'(e / Prescaler) - 64'(m_base_ticks);
   endfunction

   function automatic bit m_mapped(input logic [15:0] off);
      return off == 16'h0000 || off == 16'h4000 || off == 16'h4004 ||
             off == 16'hBFF8 || off == 16'hBFFC;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic m_reset();
      m_base = '0;
      m_base_ticks = 0;
      m_cmp = '1;
      m_msip = 1'b0;
   endtask

   // Write taking effect on the clock edge that follows sample point e.
   task automatic m_write(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s,
                          input longint unsigned e);
      logic [63:0] t;
      case (off)
         16'h0000: if (s[0]) m_msip = d[0];
         16'h4000: m_cmp[31:0] = merge(m_cmp[31:0], d, s);
         16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
         16'hBFF8, 16'hBFFC: begin
            t = m_time(e);
            if (off == 16'hBFF8) t[31:0] = merge(t[31:0], d, s);
            else                 t[63:32] = merge(t[63:32], d, s);
            m_base = t;
            m_base_ticks = (e + 1) / Prescaler;
         end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] m_read(input logic [15:0] off, input longint unsigned e);
      logic [63:0] t;
      t = m_time(e);
      case (off)
         16'h0000: return {31'd0, m_msip};
         16'h4000: return m_cmp[31:0];
         16'h4004: return m_cmp[63:32];
         16'hBFF8: return t[31:0];
         16'hBFFC: return t[63:32];
         default:  return 32'd0;
      endcase
   endfunction

   task automatic irq_idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         check_eq("timer_irq", timer_irq, m_time(edges) >= m_cmp);
         check_eq("sw_irq", sw_irq, m_msip);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [7:0] len,
                            input int w_lead, input int b_hold);
      logic [3:0] id;
      logic [1:0] exp_resp;
      int beats_left, guard;
      bit aw_hs, w_hs;
      id = 4'($urandom);
      beats_left = int'(len) + 1;
      exp_resp = (len != 0 || !m_mapped(addr[15:0])) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      @(negedge clk);
      mosi.wvalid = 1'b1;
      mosi.wdata  = data;
      mosi.wstrb  = strb;
      mosi.wlast  = (len == 0);
      repeat (w_lead) begin
         #1;
         check_eq("w_early_ready", miso.wready, 0);
         @(negedge clk);
      end
      mosi.awvalid = 1'b1;
      mosi.awaddr  = addr;
      mosi.awid    = id;
      mosi.awlen   = len;
      guard = 0;
      while (beats_left > 0 && guard < 64) begin
         #1;
         aw_hs = mosi.awvalid && miso.awready;
         w_hs  = mosi.wvalid && miso.wready;
         if (w_hs && len == 0) m_write(addr[15:0], data, strb, edges);
         @(negedge clk);
         if (aw_hs) mosi.awvalid = 1'b0;
         if (w_hs) begin
            beats_left--;
            mosi.wlast = (beats_left == 1);
            if (beats_left == 0) mosi.wvalid = 1'b0;
         end
         guard++;
      end
      if (guard >= 64) check_eq("w_timeout", 1, 0);
      mosi.awvalid = 1'b0;
      mosi.wvalid  = 1'b0;
      #1;
      check_eq("irq_after_w", timer_irq, m_time(edges) >= m_cmp);
      guard = 0;
      while (!miso.bvalid && guard < 16) begin
         @(negedge clk);
         #1;
         guard++;
      end
      check_eq("bvalid", miso.bvalid, 1);
      repeat (b_hold) begin
         @(negedge clk);
         #1;
         check_eq("b_held", {miso.bvalid, miso.bid}, {1'b1, id});
      end
      check_eq("bid", miso.bid, id);
      check_eq("bresp", miso.bresp, exp_resp);
      mosi.bready = 1'b1;
      @(negedge clk);
      mosi.bready = 1'b0;
      #1;
      check_eq("b_single", miso.bvalid, 0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input int stall_pct);
      logic [3:0]  id;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      int beat, guard;
      id = 4'($urandom);
      @(negedge clk);
      mosi.arvalid = 1'b1;
      mosi.araddr  = addr;
      mosi.arid    = id;
      mosi.arlen   = len;
      guard = 0;
      #1;
      while (!miso.arready && guard < 16) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 16) check_eq("ar_timeout", 1, 0);
      if (len != 0 || !m_mapped(addr[15:0])) begin
         exp_data = 32'd0;
         exp_resp = AXI_RESP_SLVERR;
      end else begin
         exp_data = m_read(addr[15:0], edges);
         exp_resp = AXI_RESP_OKAY;
      end
      @(negedge clk);
      mosi.arvalid = 1'b0;
      beat = 0;
      guard = 0;
      while (beat <= int'(len) && guard < 200) begin
         mosi.rready = ($urandom_range(99) >= stall_pct);
         #1;
         check_eq("rvalid", miso.rvalid, 1);
         check_eq("rdata", miso.rdata, exp_data);
         if (miso.rvalid && mosi.rready) begin
            check_eq("rresp", miso.rresp, exp_resp);
            check_eq("rid", miso.rid, id);
            check_eq("rlast", miso.rlast, beat == int'(len));
            beat++;
         end
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check_eq("r_timeout", 1, 0);
      mosi.rready = 1'b0;
      #1;
      check_eq("r_done", miso.rvalid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] t;
      logic [31:0] d;
      mosi = '0;
      offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0010};
      m_reset();

      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_awready", miso.awready, 0);
      check_eq("rst_wready", miso.wready, 0);
      check_eq("rst_bvalid", miso.bvalid, 0);
      check_eq("rst_arready", miso.arready, 0);
      check_eq("rst_rvalid", miso.rvalid, 0);
      check_eq("rst_timer_irq", timer_irq, 0);
      check_eq("rst_sw_irq", sw_irq, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("idle_awready", miso.awready, 1);
      check_eq("idle_arready", miso.arready, 1);

      irq_idle(9);
      axi_read(Base | 32'hBFF8, 8'd0, 0);

      axi_write(Base | 32'h4004, 32'd0, 4'hF, 8'd0, 0, 0);
      t = m_time(edges) + 64'd15;
      axi_write(Base | 32'h4000, t[31:0], 4'hF, 8'd0, 0, 0);
      irq_idle(25);
      axi_write(Base | 32'h4000, 32'hFFFF_FFFF, 4'hF, 8'd0, 0, 0);
      irq_idle(2);

      axi_write(Base | 32'h0000, 32'd1, 4'b0001, 8'd0, 0, 0);
      irq_idle(1);
      axi_write(Base | 32'h0000, 32'd0, 4'b0010, 8'd0, 0, 0);
      irq_idle(1);
      axi_write(Base | 32'h0000, 32'd0, 4'b0001, 8'd0, 0, 0);
      irq_idle(1);

      axi_write(Base | 32'h4004, 32'd1, 4'hF, 8'd0, 2, 5);
      axi_read(Base | 32'h4004, 8'd0, 30);

      axi_read(Base | 32'h1234, 8'd3, 40);
      axi_write(Base | 32'h4000, 32'h1234_5678, 4'hF, 8'd1, 0, 1);
      axi_read(Base | 32'h4000, 8'd0, 0);
      axi_write(Base | 32'h0100, 32'd1, 4'hF, 8'd0, 0, 0);

      axi_write(Base | 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 8'd0, 0, 0);
      axi_write(Base | 32'hBFF8, 32'hFFFF_FFFE, 4'hF, 8'd0, 0, 0);
      irq_idle(4);
      axi_read(Base | 32'hBFF8, 8'd0, 0);
      axi_read(Base | 32'hBFFC, 8'd0, 0);

      for (int it = 0; it < 60; it++) begin
         logic [15:0] off;
         off = offs[$urandom_range(5)];
         case ($urandom_range(2))
            0: axi_read(Base | {16'd0, off}, ($urandom_range(3) == 0) ? 8'($urandom_range(2)) : 8'd0,
                        $urandom_range(50));
            1: begin
               d = $urandom;
               if (off == 16'h4000 && $urandom_range(1) == 1) begin
                  t = m_time(edges) + 64'($urandom_range(30));
                  d = t[31:0];
               end
               axi_write(Base | {16'd0, off}, d, 4'($urandom_range(15)),
                         ($urandom_range(7) == 0) ? 8'd1 : 8'd0, $urandom_range(2),
                         $urandom_range(3));
            end
            default: irq_idle($urandom_range(1, 5));
         endcase
      end

      // Reset while a write response is pending.
      @(negedge clk);
      mosi.awvalid = 1'b1;
      mosi.awaddr  = Base;
      mosi.awid    = 4'h5;
      mosi.awlen   = 8'd0;
      mosi.wvalid  = 1'b1;
      mosi.wdata   = 32'd1;
      mosi.wstrb   = 4'hF;
      mosi.wlast   = 1'b1;
      @(negedge clk);
      mosi.awvalid = 1'b0;
      mosi.wvalid  = 1'b0;
      #1;
      check_eq("pre_rst_bvalid", miso.bvalid, 1);
      #2;
      rst = 1'b0;
      m_reset();
      #1;
      check_eq("mid_rst_bvalid", miso.bvalid, 0);
      check_eq("mid_rst_sw_irq", sw_irq, 0);
      check_eq("mid_rst_awready", miso.awready, 0);
      @(negedge clk);
      rst = 1'b1;
      irq_idle(3);
      axi_read(Base | 32'h0000, 8'd0, 0);
      axi_read(Base | 32'hBFF8, 8'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
